// File: rtl/xadc_drp_responder.sv
// XADC-compatible DRP responder: stores external ADC samples for VAUX7/14/15
// and answers DRP reads/writes with a fixed, parameterised latency.
module xadc_drp_responder #(
    parameter int unsigned DRP_LATENCY = 4,   // 1..15
    parameter int unsigned CFG_DEPTH   = 3    // 1..63
) (
    input  logic        CLK_100MHz,
    input  logic        SW3_RST,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [6:0]  daddr_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    input  logic        smp_valid,
    input  logic [4:0]  smp_ch,
    input  logic [11:0] smp_data,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        drp_err
);

    localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);
    localparam int unsigned CFG_BASE = 'h40;

    localparam logic [6:0] A_VAUX7  = 7'h17;
    localparam logic [6:0] A_VAUX14 = 7'h1E;
    localparam logic [6:0] A_VAUX15 = 7'h1F;
    localparam logic [6:0] A_FRESH  = 7'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [15:0]                 snap_q, snap_d;
    logic [15:0]                 do_q, do_d;
    logic                        drdy_q, drdy_d;
    logic [15:0]                 res7_q, res7_d;
    logic [15:0]                 res14_q, res14_d;
    logic [15:0]                 res15_q, res15_d;
    logic [2:0]                  fresh_q, fresh_d;   // {15, 14, 7}
    logic [CFG_DEPTH-1:0][15:0]  cfg_q, cfg_d;
    logic                        eoc_q, eoc_d;
    logic [4:0]                  chan_q, chan_d;
    logic                        err_q, err_d;

    logic        hit7, hit14, hit15, smp_ok;
    logic [15:0] rd_data;

    assign hit7   = smp_valid && (smp_ch == 5'd7);
    assign hit14  = smp_valid && (smp_ch == 5'd14);
    assign hit15  = smp_valid && (smp_ch == 5'd15);
    assign smp_ok = hit7 || hit14 || hit15;

    // Read mux works on the pre-edge register values, so a sample landing
    // on the den_in edge is not visible to that read.
    always_comb begin
        rd_data = '0;
        case (daddr_in)
            A_VAUX7:  rd_data = res7_q;
            A_VAUX14: rd_data = res14_q;
            A_VAUX15: rd_data = res15_q;
            A_FRESH:  rd_data = {13'b0, fresh_q};
            default: begin
                for (int unsigned i = 0; i < CFG_DEPTH; i++) begin
                    if (daddr_in == 7'(CFG_BASE + i)) rd_data = cfg_q[i];
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        do_d    = do_q;
        drdy_d  = 1'b0;
        res7_d  = res7_q;
        res14_d = res14_q;
        res15_d = res15_q;
        fresh_d = fresh_q;
        cfg_d   = cfg_q;
        eoc_d   = 1'b0;
        chan_d  = chan_q;
        err_d   = err_q;

        if (hit7)  res7_d  = {smp_data, 4'h0};
        if (hit14) res14_d = {smp_data, 4'h0};
        if (hit15) res15_d = {smp_data, 4'h0};
        if (smp_ok) begin
            chan_d = smp_ch;
            eoc_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (den_in) begin
                    if (dwe_in) begin
                        snap_d = '0;
                        for (int unsigned i = 0; i < CFG_DEPTH; i++) begin
                            if (daddr_in == 7'(CFG_BASE + i)) cfg_d[i] = di_in;
                        end
                    end else begin
                        snap_d = rd_data;
                        if (daddr_in == A_VAUX7)  fresh_d[0] = 1'b0;
                        if (daddr_in == A_VAUX14) fresh_d[1] = 1'b0;
                        if (daddr_in == A_VAUX15) fresh_d[2] = 1'b0;
                    end
                    cnt_d = LAT_LOAD;
                    if (DRP_LATENCY == 1) begin
                        state_d = S_RESP;
                        drdy_d  = 1'b1;
                        do_d    = snap_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (den_in) err_d = 1'b1;
                cnt_d = cnt_q - 4'd1;
                // drdy/do are registered, so leave WAIT as the count reaches 0
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    drdy_d  = 1'b1;
                    do_d    = snap_q;
                end
            end
            S_RESP: begin
                if (den_in) err_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Sample set applied last so it wins over a same-edge read clear
        if (hit7)  fresh_d[0] = 1'b1;
        if (hit14) fresh_d[1] = 1'b1;
        if (hit15) fresh_d[2] = 1'b1;
    end

    always_ff @(posedge CLK_100MHz or posedge SW3_RST) begin
        if (SW3_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            do_q    <= '0;
            drdy_q  <= 1'b0;
            res7_q  <= '0;
            res14_q <= '0;
            res15_q <= '0;
            fresh_q <= '0;
            cfg_q   <= '0;
            eoc_q   <= 1'b0;
            chan_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            do_q    <= do_d;
            drdy_q  <= drdy_d;
            res7_q  <= res7_d;
            res14_q <= res14_d;
            res15_q <= res15_d;
            fresh_q <= fresh_d;
            cfg_q   <= cfg_d;
            eoc_q   <= eoc_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
        end
    end

    assign do_out      = do_q;
    assign drdy_out    = drdy_q;
    assign eoc_out     = eoc_q;
    assign channel_out = chan_q;
    assign drp_err     = err_q;

endmodule
